// File: rtl/flap_input_ctrl.sv
// Flap button conditioning and game sequencer: synchronises the raw key into
// single-cycle press pulses, paces gravity pulses and tracks IDLE/PLAY/OVER.
module flap_input_ctrl #(
    parameter int GRAV_PERIOD = 8,
    parameter int HANG_CYCLES = 12,
    parameter int CNT_W = $clog2((GRAV_PERIOD > HANG_CYCLES) ? GRAV_PERIOD : HANG_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_raw,
    input  logic       game_over,
    output logic       press,
    output logic       gravity,
    output logic       playing,
    output logic [7:0] flap_count
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    localparam logic [CNT_W-1:0] HANG_LOAD = CNT_W'(HANG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRAV_LOAD = CNT_W'(GRAV_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic             s1, s2, kd;
    logic             key_edge;
    logic             press_d, grav_d, playing_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       flaps_d;

    assign key_edge = s2 & ~kd;

    // Sync flops reset to 1 so a key held through reset must be released first.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            kd         <= 1'b1;
            state_q    <= IDLE;
            press      <= 1'b0;
            gravity    <= 1'b0;
            playing    <= 1'b0;
            cnt_q      <= '0;
            flap_count <= '0;
        end else begin
            s1         <= key_raw;
            s2         <= s1;
            kd         <= s2;
            state_q    <= state_d;
            press      <= press_d;
            gravity    <= grav_d;
            playing    <= playing_d;
            cnt_q      <= cnt_d;
            flap_count <= flaps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        grav_d  = 1'b0;
        cnt_d   = cnt_q;
        flaps_d = flap_count;
        case (state_q)
            IDLE: begin
                if (key_edge) begin
                    state_d = PLAY;
                    press_d = 1'b1;
                    cnt_d   = HANG_LOAD;
                    flaps_d = 8'd1;
                end
            end
            PLAY: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (key_edge) begin
                    press_d = 1'b1;
                    cnt_d   = HANG_LOAD;
                    if (flap_count != '1)
                        flaps_d = flap_count + 8'd1;
                end else if (cnt_q == '0) begin
                    grav_d = 1'b1;
                    cnt_d  = GRAV_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            OVER: begin
                if (key_edge)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        playing_d = (state_d == PLAY);
    end

endmodule

// File: tb/tb_flap_input_ctrl.sv
// Bench for flap_input_ctrl: directed scenarios with literal expectations plus
// random key/game_over/reset traffic checked against a cycle-time reference model.
module tb_flap_input_ctrl;

    localparam int G = 4;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset, key_raw, game_over;
    logic       press, gravity, playing;
    logic [7:0] flap_count;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    flap_input_ctrl #(.GRAV_PERIOD(G), .HANG_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw), .game_over(game_over),
        .press(press), .gravity(gravity), .playing(playing), .flap_count(flap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=play 2=over; gravity timed by absolute cycle.
    int phase = 0;
    int cyc = 0;
    int due = 0;
    int m_press = 0, m_grav = 0, m_flaps = 0;
    bit hist [3] = '{1'b1, 1'b1, 1'b1};  // key samples 1, 2 and 3 edges ago

    always @(posedge clk) begin
        bit rose;
        if (reset) begin
            phase = 0; m_press = 0; m_grav = 0; m_flaps = 0;
            hist = '{1'b1, 1'b1, 1'b1};
        end else begin
            rose = hist[1] & ~hist[2];
            m_press = 0;
            m_grav  = 0;
            if (phase == 0) begin
                if (rose) begin
                    phase = 1; m_press = 1; m_flaps = 1; due = cyc + H;
                end
            end else if (phase == 1) begin
                if (game_over) phase = 2;
                else if (rose) begin
                    m_press = 1; due = cyc + H;
                    m_flaps = (m_flaps >= 255) ? 255 : m_flaps + 1;
                end else if (cyc == due) begin
                    m_grav = 1; due = cyc + G;
                end
            end else if (rose) phase = 0;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = key_raw;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("press", press, m_press);
            chk("gravity", gravity, m_grav);
            chk("playing", playing, (phase == 1) ? 1 : 0);
            chk("flap_count", flap_count, m_flaps);
            chk("press_gravity_excl", press & gravity, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; key_raw = 1'b1; game_over = 1'b0;
        tick();
        chk_en = 1'b1;
        // 1: key held through reset, then still held after release: no edge
        for (int i = 0; i < 9; i++) tick();
        chk("rst_press", press, 0);
        chk("rst_playing", playing, 0);
        chk("rst_flaps", flap_count, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("held_through_reset", playing, 0);
        key_raw = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        // 2: key sampled at edge N gives press after edge N+2
        key_raw = 1'b1;
        tick(); tick();
        chk("press_not_early", press, 0);
        tick();
        chk("start_press", press, 1);
        chk("start_playing", playing, 1);
        chk("start_flaps", flap_count, 1);
        // 3/4: gravity cadence, then a press landing on a due gravity slot
        key_raw = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            if (k == 20) key_raw = 1'b1;
            if (k == 25) key_raw = 1'b0;
            tick();
            chk($sformatf("grav_k%0d", k), gravity, (k == 6 || k == 10 || k == 14 || k == 18 || k == 28) ? 1 : 0);
            chk($sformatf("press_k%0d", k), press, (k == 22) ? 1 : 0);
            if (k == 22) chk("flaps_2", flap_count, 2);
        end
        // 5: game over, then one press to IDLE, another to restart
        game_over = 1'b1;
        tick();
        chk("over_playing", playing, 0);
        for (int i = 0; i < 5; i++) tick();
        game_over = 1'b0;
        key_raw = 1'b1;
        tick(); tick(); tick();
        chk("over_to_idle_press", press, 0);
        chk("over_flaps_hold", flap_count, 2);
        chk("idle_playing", playing, 0);
        key_raw = 1'b0;
        tick(); tick(); tick();
        key_raw = 1'b1;
        tick(); tick(); tick();
        chk("restart_press", press, 1);
        chk("restart_flaps", flap_count, 1);
        chk("restart_playing", playing, 1);
        key_raw = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        // 6: held key gives one press; many presses saturate the count
        key_raw = 1'b1;
        cnt = 0;
        for (int i = 0; i < 23; i++) begin
            if (i == 20) key_raw = 1'b0;
            tick();
            cnt += int'(press);
        end
        chk("held_one_press", cnt, 1);
        chk("held_flaps", flap_count, 2);
        for (int i = 0; i < 300; i++) begin
            key_raw = 1'b1; tick(); tick();
            key_raw = 1'b0; tick(); tick();
        end
        tick(); tick();
        chk("flaps_saturate", flap_count, 255);
        // reset mid-play clears everything at once
        reset = 1'b1;
        tick();
        chk("midrst_press", press, 0);
        chk("midrst_gravity", gravity, 0);
        chk("midrst_playing", playing, 0);
        chk("midrst_flaps", flap_count, 0);
        reset = 1'b0;
        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) key_raw = ~key_raw;
            game_over = ($urandom_range(0, 60) == 0);
            reset = ($urandom_range(0, 700) == 0);
            tick();
        end
        reset = 1'b0; game_over = 1'b0; key_raw = 1'b0;
        tick(); tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
